// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand stage.
// Defines the op bundle carried by the main and skid registers.
package alu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic              mode;
    logic [REG_AW-1:0] rd;
  } op_t;

  localparam int OP_W = $bits(op_t);

endpackage

// File: rtl/alu_operand_stage_skid_buffer.sv
// Two-entry valid/ready buffer (main + skid) with a registered in_ready.
// Strict FIFO order; flush drops both entries.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         main_free;

  // in_ready comes straight from a flop, so there is no ready path from out_ready.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments only; both entries,
  // data included, are reset so outputs read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/alu_operand_stage.sv
// Operand resolution stage feeding the 32-bit adder_subtractor.
// Optional writeback forwarding is enabled by defining OPERAND_FWD_EN.
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic              in_sub,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [XLEN-1:0]   fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic              out_mode,
  output logic [REG_AW-1:0] out_rd
);

  op_t resolved;
  op_t held;

  // NOTE: every field gets a default first so this block cannot infer a latch.
  always_comb begin
    resolved      = '0;
    resolved.a    = in_rs1_data;
    resolved.b    = in_use_imm ? in_imm : in_rs2_data;
    resolved.mode = in_sub ? MODE_SUB : MODE_ADD;
    resolved.rd   = in_rd;
`ifdef OPERAND_FWD_EN
    // Register 0 is hardwired zero and must never pick up a forwarded value.
    if (fwd_valid && fwd_rd != '0 && fwd_rd == in_rs1_addr)
      resolved.a = fwd_data;
    if (fwd_valid && fwd_rd != '0 && fwd_rd == in_rs2_addr && !in_use_imm)
      resolved.b = fwd_data;
`endif
  end

`ifndef OPERAND_FWD_EN
  logic fwd_unused;
  assign fwd_unused = ^{fwd_valid, fwd_rd, fwd_data, in_rs1_addr, in_rs2_addr};
`endif

  skid_buffer #(
    .W(OP_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (resolved),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (held)
  );

  assign out_a    = held.a;
  assign out_b    = held.b;
  assign out_mode = held.mode;
  assign out_rd   = held.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected ops are queued at accept
// and compared in order when the stage hands them to the adder.
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs1_addr = '0;
  logic [REG_AW-1:0] in_rs2_addr = '0;
  logic [XLEN-1:0]   in_rs1_data = '0;
  logic [XLEN-1:0]   in_rs2_data = '0;
  logic [XLEN-1:0]   in_imm = '0;
  logic              in_use_imm = 1'b0;
  logic              in_sub = 1'b0;
  logic [REG_AW-1:0] in_rd = '0;
  logic              fwd_valid = 1'b0;
  logic [REG_AW-1:0] fwd_rd = '0;
  logic [XLEN-1:0]   fwd_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [XLEN-1:0]   out_a;
  logic [XLEN-1:0]   out_b;
  logic              out_mode;
  logic [REG_AW-1:0] out_rd;

  int  n_compared = 0;
  int  n_mismatched = 0;
  op_t sb_q[$];

  alu_operand_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1_addr (in_rs1_addr),
    .in_rs2_addr (in_rs2_addr),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .in_imm      (in_imm),
    .in_use_imm  (in_use_imm),
    .in_sub      (in_sub),
    .in_rd       (in_rd),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_mode    (out_mode),
    .out_rd      (out_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference resolution, written directly from the operand rules.
  function automatic op_t model_op();
    op_t m;
    m.a    = in_rs1_data;
    m.b    = in_use_imm ? in_imm : in_rs2_data;
    m.mode = in_sub;
    m.rd   = in_rd;
`ifdef OPERAND_FWD_EN
    if (fwd_valid && fwd_rd != 0 && fwd_rd == in_rs1_addr) m.a = fwd_data;
    if (fwd_valid && fwd_rd != 0 && fwd_rd == in_rs2_addr && !in_use_imm) m.b = fwd_data;
`endif
    return m;
  endfunction

  // Monitor: compare handed-off ops, then record newly accepted ones.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          op_t e;
          e = sb_q.pop_front();
          check("out_a", out_a, e.a);
          check("out_b", out_b, e.b);
          check("out_mode", out_mode, e.mode);
          check("out_rd", out_rd, e.rd);
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(model_op());
    end
  end

  task automatic drive(input logic [REG_AW-1:0] rs1a, input logic [REG_AW-1:0] rs2a,
                       input logic [XLEN-1:0] rs1d, input logic [XLEN-1:0] rs2d,
                       input logic [XLEN-1:0] imm, input logic use_imm,
                       input logic sub, input logic [REG_AW-1:0] rd);
    in_rs1_addr = rs1a;
    in_rs2_addr = rs2a;
    in_rs1_data = rs1d;
    in_rs2_data = rs2d;
    in_imm      = imm;
    in_use_imm  = use_imm;
    in_sub      = sub;
    in_rd       = rd;
    in_valid    = 1'b1;
  endtask

  // Offer one op and hold it until accepted, bounded by a cycle budget.
  task automatic send(input logic [REG_AW-1:0] rs1a, input logic [REG_AW-1:0] rs2a,
                      input logic [XLEN-1:0] rs1d, input logic [XLEN-1:0] rs2d,
                      input logic [XLEN-1:0] imm, input logic use_imm,
                      input logic sub, input logic [REG_AW-1:0] rd);
    bit done = 1'b0;
    drive(rs1a, rs2a, rs1d, rs2d, imm, use_imm, sub, rd);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_a", out_a, '0);
    check("rst_out_b", out_b, '0);
    check("rst_out_mode", out_mode, 1'b0);
    check("rst_out_rd", out_rd, '0);
    @(posedge clk);
    #1;

    // Subtract, registers only; out_valid one cycle after accept.
    send(5'd1, 5'd2, 32'd5, 32'd3, 32'd0, 1'b0, 1'b1, 5'd7);
    @(negedge clk);
    check("lat_out_valid", out_valid, 1'b1);
    check("lat_out_a", out_a, 32'd5);
    check("lat_out_mode", out_mode, MODE_SUB);
    idle(1);

    // Immediate operand replaces rs2; also subtract with immediate.
    send(5'd3, 5'd6, 32'd10, 32'd9, 32'hFFFF_FFFC, 1'b1, 1'b0, 5'd2);
    send(5'd3, 5'd6, 32'h1234, 32'd9, 32'h0000_0010, 1'b1, 1'b1, 5'd31);
    idle(3);

    // Backpressure: X to main, Y to skid, Z held off.
    out_ready = 1'b0;
    send(5'd1, 5'd2, 32'hA, 32'h1, 32'd0, 1'b0, 1'b0, 5'd10);
    send(5'd1, 5'd2, 32'hB, 32'h2, 32'd0, 1'b0, 1'b1, 5'd11);
    drive(5'd1, 5'd2, 32'hC, 32'h3, 32'd0, 1'b0, 1'b0, 5'd12);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_out_a_stable", out_a, 32'hA);
    @(posedge clk);
    #1;
    check("bp_still_full", in_ready, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_x_valid", out_valid, 1'b1);
    check("bp_drain_x_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_drain_y_valid", out_valid, 1'b1);
    check("bp_z_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_drain_z_valid", out_valid, 1'b1);
    idle(2);

    // Forwarding: both sources match, then register 0, then immediate B.
    fwd_valid = 1'b1;
    fwd_rd    = 5'd4;
    fwd_data  = 32'hAA;
    send(5'd4, 5'd4, 32'h11, 32'h22, 32'd0, 1'b0, 1'b0, 5'd8);
    fwd_rd = 5'd0;
    send(5'd0, 5'd0, 32'h33, 32'h44, 32'd0, 1'b0, 1'b0, 5'd9);
    fwd_rd = 5'd4;
    send(5'd4, 5'd4, 32'h55, 32'h66, 32'h77, 1'b1, 1'b1, 5'd13);
    fwd_valid = 1'b0;
    idle(3);

    // Flush with two ops held and a new op offered.
    out_ready = 1'b0;
    send(5'd1, 5'd1, 32'h100, 32'h1, 32'd0, 1'b0, 1'b0, 5'd14);
    send(5'd1, 5'd1, 32'h200, 32'h2, 32'd0, 1'b0, 1'b0, 5'd15);
    drive(5'd1, 5'd1, 32'h300, 32'h3, 32'd0, 1'b0, 1'b0, 5'd16);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    idle(3);

    // Asynchronous reset between edges with two ops held.
    out_ready = 1'b0;
    send(5'd1, 5'd1, 32'h400, 32'h4, 32'd0, 1'b0, 1'b0, 5'd17);
    send(5'd1, 5'd1, 32'h500, 32'h5, 32'd0, 1'b0, 1'b0, 5'd18);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_a", out_a, '0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(5'd2, 5'd3, 32'h600, 32'h6, 32'd0, 1'b0, 1'b1, 5'd19);
    idle(4);

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
